// File: rtl/quad_input_filter.sv
// Quadrature input conditioner: synchronizes raw A/B, accepts a new {a,b} only after it
// has held for FILT_LEN sampled cycles, and flags single-bit steps and illegal double-bit jumps.
module quad_input_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_raw,
    input  logic        b_raw,
    input  logic        err_clr,
    output logic        a,
    output logic        b,
    output logic        step,
    output logic        err,
    output logic [15:0] err_count
);

    localparam logic [7:0] FILT_LEN_C = 8'(FILT_LEN);

    // Classifies an accepted transition: bit 1 = single-bit step, bit 0 = double-bit error.
    function automatic logic [1:0] classify_change(input logic [1:0] old_v, input logic [1:0] new_v);
        logic [1:0] res;
        case (old_v ^ new_v)
            2'b01, 2'b10: res = 2'b10;
            2'b11:        res = 2'b01;
            default:      res = 2'b00;
        endcase
        return res;
    endfunction

    logic [1:0]  sync1_r;
    logic [1:0]  samp_r;
    logic [1:0]  cand_r;
    logic [7:0]  cnt_r;
    logic [1:0]  out_r;
    logic        step_r;
    logic        err_r;
    logic [15:0] err_count_r;

    logic [1:0]  cand_n_s;
    logic [7:0]  cnt_n_s;
    logic [7:0]  run_s;
    logic [1:0]  out_n_s;
    logic        step_n_s;
    logic        err_n_s;

    // Two-flop synchronizer for the asynchronous encoder channels.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 2'b00;
            samp_r  <= 2'b00;
        end else begin
            sync1_r <= {a_raw, b_raw};
            samp_r  <= sync1_r;
        end
    end

    // Stability filter: counts how long a differing sample has held before accepting it.
    always_comb begin
        cand_n_s = cand_r;
        cnt_n_s  = cnt_r;
        run_s    = 8'd0;
        out_n_s  = out_r;
        step_n_s = 1'b0;
        err_n_s  = 1'b0;
        if (samp_r == out_r) begin
            cnt_n_s = 8'd0;
        end else begin
            if (samp_r == cand_r) begin
                run_s = (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
            end else begin
                run_s = 8'd1;
            end
            cand_n_s = samp_r;
            if (run_s >= FILT_LEN_C) begin
                out_n_s               = samp_r;
                cnt_n_s               = 8'd0;
                {step_n_s, err_n_s}   = classify_change(out_r, samp_r);
            end else begin
                cnt_n_s = run_s;
            end
        end
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_r <= 2'b00;
            cnt_r  <= 8'd0;
            out_r  <= 2'b00;
            step_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            cand_r <= cand_n_s;
            cnt_r  <= cnt_n_s;
            out_r  <= out_n_s;
            step_r <= step_n_s;
            err_r  <= err_n_s;
        end
    end

    // Saturating error counter; clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count_r <= 16'd0;
        end else if (err_clr) begin
            err_count_r <= 16'd0;
        end else if (err_n_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'd1;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign a         = out_r[1];
    assign b         = out_r[0];
    assign step      = step_r;
    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_quad_input_filter.sv
// Bench for quad_input_filter: window-based reference model (FILT_LEN=4 instance)
// plus a FILT_LEN=1 instance used to reach err_count saturation quickly.
module tb_quad_input_filter;

    localparam int FILT = 4;

    logic clk = 1'b0;
    logic rst;
    logic a_raw, b_raw, err_clr;
    logic a, b, step, err;
    logic [15:0] err_count;
    logic a1_raw, b1_raw, err_clr1;
    logic a1, b1, step1, err1;
    logic [15:0] err_count1;

    int checks = 0;
    int errors = 0;

    // model state
    logic [1:0]  m_s1, m_s2, m_out;
    logic        m_step, m_err;
    logic [15:0] m_ecnt;
    logic [1:0]  hist[$];

    always #5 clk = ~clk;

    quad_input_filter #(.FILT_LEN(FILT)) dut (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw), .err_clr(err_clr),
        .a(a), .b(b), .step(step), .err(err), .err_count(err_count)
    );

    quad_input_filter #(.FILT_LEN(1)) dut1 (
        .clk(clk), .rst(rst), .a_raw(a1_raw), .b_raw(b1_raw), .err_clr(err_clr1),
        .a(a1), .b(b1), .step(step1), .err(err1), .err_count(err_count1)
    );

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_out = 2'b00;
        m_step = 1'b0; m_err = 1'b0; m_ecnt = 16'd0;
        hist.delete();
    endtask

    // A new value is accepted once the last FILT samples seen by the filter all equal it.
    task automatic model_step();
        logic [1:0] samp_v;
        logic       ok;
        samp_v = m_s2;
        m_step = 1'b0;
        m_err  = 1'b0;
        hist.push_back(samp_v);
        if (hist.size() > FILT) void'(hist.pop_front());
        ok = (hist.size() == FILT) && (samp_v != m_out);
        foreach (hist[i]) if (hist[i] != samp_v) ok = 1'b0;
        if (ok) begin
            if ((samp_v ^ m_out) == 2'b11) m_err = 1'b1;
            else m_step = 1'b1;
            m_out = samp_v;
        end
        if (err_clr) m_ecnt = 16'd0;
        else if (m_err && m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 16'd1;
        m_s2 = m_s1;
        m_s1 = {a_raw, b_raw};
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; a_raw = 1'b0; b_raw = 1'b0; err_clr = 1'b0;
        a1_raw = 1'b0; b1_raw = 1'b0; err_clr1 = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({a, b, step, err, err_count} !== 20'd0) begin
            errors++;
            $display("FAIL reset: got ab=%b%b step=%b err=%b cnt=%h want all 0", a, b, step, err, err_count);
        end
        checks++;
        if ({a1, b1, step1, err1, err_count1} !== 20'd0) begin
            errors++;
            $display("FAIL reset1: got ab=%b%b step=%b err=%b cnt=%h want all 0", a1, b1, step1, err1, err_count1);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic test_single_step();
        {a_raw, b_raw} = 2'b10;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if ({a, b, step, err} !== {((k >= 5) ? 2'b10 : 2'b00), (k == 5), 1'b0}) begin
                errors++;
                $display("FAIL latency edge%0d: got ab=%b%b step=%b err=%b want ab=%b step=%b err=0",
                         k, a, b, step, err, (k >= 5) ? 2'b10 : 2'b00, k == 5);
            end
            checks++;
            if ({a, b, step, err, err_count} !== {m_out, m_step, m_err, m_ecnt}) begin
                errors++;
                $display("FAIL single model: got ab=%b%b step=%b err=%b cnt=%h want ab=%b step=%b err=%b cnt=%h",
                         a, b, step, err, err_count, m_out, m_step, m_err, m_ecnt);
            end
        end
    endtask

    task automatic test_glitch();
        {a_raw, b_raw} = 2'b00;
        repeat (10) cycle();
        for (int k = 0; k < 15; k++) begin
            {a_raw, b_raw} = (k < 3) ? 2'b10 : 2'b00;
            cycle();
            checks++;
            if ({a, b, step, err, err_count} !== 20'd0) begin
                errors++;
                $display("FAIL glitch cyc%0d: got ab=%b%b step=%b err=%b cnt=%h want all 0",
                         k, a, b, step, err, err_count);
            end
        end
    endtask

    task automatic test_sequence();
        logic [1:0] seq [4];
        int steps_seen;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        steps_seen = 0;
        for (int s = 0; s < 4; s++) begin
            {a_raw, b_raw} = seq[s];
            for (int k = 0; k < 10; k++) begin
                cycle();
                if (step) steps_seen++;
                checks++;
                if ({a, b, step, err, err_count} !== {m_out, m_step, m_err, m_ecnt}) begin
                    errors++;
                    $display("FAIL sequence s%0d c%0d: got ab=%b%b step=%b err=%b cnt=%h want ab=%b step=%b err=%b cnt=%h",
                             s, k, a, b, step, err, err_count, m_out, m_step, m_err, m_ecnt);
                end
            end
            checks++;
            if ({a, b} !== seq[s]) begin
                errors++;
                $display("FAIL sequence value s%0d: got %b%b want %b", s, a, b, seq[s]);
            end
        end
        checks++;
        if (steps_seen != 4 || err_count !== 16'd0) begin
            errors++;
            $display("FAIL sequence steps: got steps=%0d cnt=%h want steps=4 cnt=0", steps_seen, err_count);
        end
    endtask

    task automatic test_err();
        int errs_seen;
        errs_seen = 0;
        for (int s = 0; s < 3; s++) begin
            {a_raw, b_raw} = (s == 1) ? 2'b00 : 2'b11;
            for (int k = 0; k < 10; k++) begin
                cycle();
                if (err) errs_seen++;
                checks++;
                if ({a, b, step, err, err_count} !== {m_out, m_step, m_err, m_ecnt}) begin
                    errors++;
                    $display("FAIL err model s%0d c%0d: got ab=%b%b step=%b err=%b cnt=%h want ab=%b step=%b err=%b cnt=%h",
                             s, k, a, b, step, err, err_count, m_out, m_step, m_err, m_ecnt);
                end
            end
        end
        checks++;
        if (errs_seen != 3 || err_count !== 16'd3) begin
            errors++;
            $display("FAIL err count: got pulses=%0d cnt=%h want pulses=3 cnt=0003", errs_seen, err_count);
        end
        {a_raw, b_raw} = 2'b00;
        repeat (5) cycle();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        checks++;
        if ({a, b, err, err_count} !== {2'b00, 1'b1, 16'd0}) begin
            errors++;
            $display("FAIL err clr priority: got ab=%b%b err=%b cnt=%h want ab=00 err=1 cnt=0000", a, b, err, err_count);
        end
        repeat (3) cycle();
    endtask

    task automatic test_random();
        logic [1:0] v;
        int len;
        for (int n = 0; n < 80; n++) begin
            v   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 7);
            {a_raw, b_raw} = v;
            for (int k = 0; k < len; k++) begin
                err_clr = ($urandom_range(0, 15) == 0);
                cycle();
                checks++;
                if ({a, b, step, err, err_count} !== {m_out, m_step, m_err, m_ecnt}) begin
                    errors++;
                    $display("FAIL random n%0d: got ab=%b%b step=%b err=%b cnt=%h want ab=%b step=%b err=%b cnt=%h",
                             n, a, b, step, err, err_count, m_out, m_step, m_err, m_ecnt);
                end
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        {a_raw, b_raw} = 2'b00;
        repeat (10) cycle();
        {a_raw, b_raw} = 2'b10;
        repeat (4) cycle();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({a, b, step, err, err_count} !== 20'd0) begin
            errors++;
            $display("FAIL mid reset: got ab=%b%b step=%b err=%b cnt=%h want all 0", a, b, step, err, err_count);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if ({a, b, step, err} !== {((k >= 5) ? 2'b10 : 2'b00), (k == 5), 1'b0}) begin
                errors++;
                $display("FAIL reset latency edge%0d: got ab=%b%b step=%b err=%b want ab=%b step=%b err=0",
                         k, a, b, step, err, (k >= 5) ? 2'b10 : 2'b00, k == 5);
            end
            checks++;
            if ({a, b, step, err, err_count} !== {m_out, m_step, m_err, m_ecnt}) begin
                errors++;
                $display("FAIL reset model: got ab=%b%b step=%b err=%b cnt=%h want ab=%b step=%b err=%b cnt=%h",
                         a, b, step, err, err_count, m_out, m_step, m_err, m_ecnt);
            end
        end
    endtask

    task automatic test_saturate();
        int pulses;
        {a1_raw, b1_raw} = 2'b00;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 65534; i++) begin
            {a1_raw, b1_raw} = ~{a1_raw, b1_raw};
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (err_count1 !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat FFFE: got %h want fffe", err_count1);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 2) {a1_raw, b1_raw} = ~{a1_raw, b1_raw};
            @(negedge clk);
            if (err1) pulses++;
        end
        checks++;
        if (err_count1 !== 16'hFFFF || pulses != 2) begin
            errors++;
            $display("FAIL sat FFFF: got cnt=%h pulses=%0d want cnt=ffff pulses=2", err_count1, pulses);
        end
        for (int i = 0; i < 8; i++) begin
            if (i < 3) {a1_raw, b1_raw} = ~{a1_raw, b1_raw};
            @(negedge clk);
        end
        checks++;
        if (err_count1 !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat hold: got %h want ffff", err_count1);
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_glitch();
        test_sequence();
        test_err();
        test_random();
        test_reset_mid();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
